// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port synchronous RAM with fixed wait states.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: m0 always wins ties (no round-robin).
module mem_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int RAM_AW      = 10
) (
    input  logic              clk,
    input  logic              res,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_be,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_be,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_ack,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;
    localparam logic [3:0] LP_WS    = 4'(WAIT_STATES);

    logic [1:0]        r_state;
    logic              r_owner;
    logic [3:0]        r_wcnt;
    logic              r_we;
    logic [3:0]        r_be;
    logic [RAM_AW-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_m0_rdata;
    logic [31:0]       r_m1_rdata;
    logic              w_sel;
    logic              w_access;

    // Byte-offset and out-of-range address bits never reach the RAM.
    logic w_unused;
    assign w_unused = &{1'b0, m0_addr[31:RAM_AW+2], m0_addr[1:0],
                        m1_addr[31:RAM_AW+2], m1_addr[1:0]};

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_sel = ~m0_req;
`else
    logic r_last;

    // On a tie the master that was not served last wins.
    assign w_sel = (m0_req & m1_req) ? ~r_last : m1_req;

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            r_last <= 1'b1;
        else if (r_state == S_IDLE && (m0_req || m1_req))
            r_last <= w_sel;
    end
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_wcnt     <= 4'd0;
            r_we       <= 1'b0;
            r_be       <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_m0_rdata <= 32'd0;
            r_m1_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        r_owner <= w_sel;
                        r_we    <= w_sel ? m1_we : m0_we;
                        r_be    <= w_sel ? m1_be : m0_be;
                        r_addr  <= w_sel ? m1_addr[RAM_AW+1:2] : m0_addr[RAM_AW+1:2];
                        r_wdata <= w_sel ? m1_wdata : m0_wdata;
                        r_wcnt  <= 4'd0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_wcnt <= r_wcnt + 4'd1;
                    if (r_wcnt == LP_WS) begin
                        if (!r_we) begin
                            if (r_owner) r_m1_rdata <= ram_rdata;
                            else         r_m0_rdata <= ram_rdata;
                        end
                        r_state <= S_ACK;
                    end
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_access  = (r_state == S_ACCESS);
    // Single write strobe in the address phase only.
    assign ram_we    = w_access & r_we & (r_wcnt == 4'd0);
    assign ram_be    = w_access ? r_be    : 4'd0;
    assign ram_addr  = w_access ? r_addr  : '0;
    assign ram_wdata = w_access ? r_wdata : 32'd0;
    assign m0_ack    = (r_state == S_ACK) & ~r_owner;
    assign m1_ack    = (r_state == S_ACK) &  r_owner;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model with random rounds.
module tb_mem_arbiter;
    localparam int WS  = 1;
    localparam int RAW = 10;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic res;
    logic m0_req, m0_we, m1_req, m1_we;
    logic [3:0] m0_be, m1_be, ram_be;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic m0_ack, m1_ack, ram_we, busy;
    logic [RAW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] ram_arr [1024] = '{default: 32'd0};
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [31:0] pl_data = 32'd0;

    // Transaction-level model state
    logic [31:0] mdl_mem [1024] = '{default: 32'd0};
    logic [31:0] exp_rd [2];
    int          m_last;
    logic        t_we [2];
    logic [3:0]  t_be [2];
    logic [31:0] t_addr [2];
    logic [31:0] t_wd [2];
    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_STATES(WS), .RAM_AW(RAW)) u_dut (
        .clk(clk), .res(res),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    // Registered-read RAM with byte-enable writes
    always @(posedge clk) begin
        if (pl_en) ram_arr[pl_addr] <= pl_data;
        else if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) ram_arr[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= ram_arr[ram_addr];
    end

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = 10'(idx); pl_data = d;
        mdl_mem[idx] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic set_txn(input int m, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wd);
        t_we[m] = we; t_be[m] = be; t_addr[m] = addr; t_wd[m] = wd;
    endtask

    task automatic model_apply(input int o);
        int idx;
        idx = int'(t_addr[o][11:2]);
        if (t_we[o]) begin
            for (int b = 0; b < 4; b++)
                if (t_be[o][b]) mdl_mem[idx][8*b +: 8] = t_wd[o][8*b +: 8];
        end else begin
            exp_rd[o] = mdl_mem[idx];
        end
    endtask

    // One or two masters request together; each is served once, in arbitration order.
    task automatic run_round(input logic r0, input logic r1, input int drop_at, input string tag);
        int ord [2];
        int nt, last_n, base, o;
        logic e_busy, e_we;
        logic [3:0] e_be;
        logic [RAW-1:0] e_addr;
        logic [31:0] e_wd;
        logic [1:0] e_ack;
        logic [49:0] act, exp;
        nt = int'(r0) + int'(r1);
        if (r0 && r1) ord[0] = (FIXED || m_last == 1) ? 0 : 1;
        else          ord[0] = r0 ? 0 : 1;
        ord[1] = 1 - ord[0];
        for (int k = 0; k < nt; k++) m_last = ord[k];
        @(negedge clk);
        if (r0) begin m0_req = 1'b1; m0_we = t_we[0]; m0_be = t_be[0]; m0_addr = t_addr[0]; m0_wdata = t_wd[0]; end
        if (r1) begin m1_req = 1'b1; m1_we = t_we[1]; m1_be = t_be[1]; m1_addr = t_addr[1]; m1_wdata = t_wd[1]; end
        last_n = (nt - 1) * (WS + 3) + WS + 3;
        for (int n = 1; n <= last_n; n++) begin
            @(negedge clk);
            if (n == drop_at) begin m0_req = 1'b0; m1_req = 1'b0; end
            e_busy = 1'b0; e_we = 1'b0; e_be = 4'd0; e_addr = '0; e_wd = 32'd0; e_ack = 2'b00;
            for (int k = 0; k < nt; k++) begin
                base = k * (WS + 3); o = ord[k];
                if (n > base && n <= base + WS + 1) begin
                    e_busy = 1'b1; e_we = t_we[o] && (n == base + 1);
                    e_be = t_be[o]; e_addr = t_addr[o][11:2]; e_wd = t_wd[o];
                end else if (n == base + WS + 2) begin
                    e_busy = 1'b1; e_ack[o] = 1'b1;
                end
            end
            act = {busy, ram_we, ram_be, ram_addr, ram_wdata, m1_ack, m0_ack};
            exp = {e_busy, e_we, e_be, e_addr, e_wd, e_ack};
            ntot++;
            if (act !== exp) $display("FAIL %s bus n=%0d: got %h want %h", tag, n, act, exp);
            else npass++;
            for (int k = 0; k < nt; k++) begin
                if (n == k * (WS + 3) + WS + 2) begin
                    o = ord[k];
                    model_apply(o);
                    if (o == 0) m0_req = 1'b0; else m1_req = 1'b0;
                    ntot++;
                    if ({m0_rdata, m1_rdata} !== {exp_rd[0], exp_rd[1]})
                        $display("FAIL %s rdata n=%0d: got %h/%h want %h/%h", tag, n,
                                 m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
                    else npass++;
                end
            end
        end
    endtask

    task automatic do_reset();
        res = 1'b0;
        m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
        m_last = 1; exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    endtask

    task automatic test_reset();
        do_reset();
        preload(0, 32'hA5A5_0001);
        preload(1, 32'h5A5A_0002);
        ntot++;
        if ({busy, ram_we, ram_be, ram_addr, ram_wdata, m0_ack, m1_ack, m0_rdata, m1_rdata} !== 114'd0)
            $display("FAIL reset_outputs: got busy=%b we=%b ack=%b%b rd=%h/%h want all 0",
                     busy, ram_we, m0_ack, m1_ack, m0_rdata, m1_rdata);
        else npass++;
        @(negedge clk); res = 1'b1;
    endtask

    // Both masters keep req high: grants follow the tie rule, spaced WS+3 apart.
    task automatic test_contention();
        int o;
        logic [1:0] e_ack;
        set_txn(0, 1'b0, 4'hF, 32'h0000_0000, 32'd0);
        set_txn(1, 1'b0, 4'hF, 32'h0000_0004, 32'd0);
        @(negedge clk);
        m0_req = 1'b1; m0_addr = t_addr[0]; m0_be = 4'hF;
        m1_req = 1'b1; m1_addr = t_addr[1]; m1_be = 4'hF;
        for (int n = 1; n <= 3 * (WS + 3) + WS + 2; n++) begin
            @(negedge clk);
            e_ack = 2'b00; o = -1;
            for (int k = 0; k < 4; k++)
                if (n == k * (WS + 3) + WS + 2) begin
                    o = FIXED ? 0 : (k % 2);
                    e_ack[o] = 1'b1;
                end
            ntot++;
            if ({m1_ack, m0_ack} !== e_ack) $display("FAIL contention n=%0d: got ack %b%b want %b", n, m1_ack, m0_ack, e_ack);
            else npass++;
            if (o >= 0) begin m_last = o; model_apply(o); end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        ntot++;
        if ({m0_rdata, m1_rdata} !== {exp_rd[0], exp_rd[1]})
            $display("FAIL contention_rdata: got %h/%h want %h/%h", m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]);
        else npass++;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        preload(5, 32'hDEAD_BEEF);
        set_txn(0, 1'b0, 4'hF, 32'h0000_0014, 32'h1111_2222);
        run_round(1'b1, 1'b0, 0, "single_read");
        ntot++;
        if (m0_rdata !== 32'hDEAD_BEEF) $display("FAIL single_read_data: got %h want DEADBEEF", m0_rdata);
        else npass++;
    endtask

    task automatic test_byte_write();
        set_txn(1, 1'b1, 4'b0010, 32'h0000_0008, 32'h0000_AB00);
        run_round(1'b0, 1'b1, 0, "byte_write");
        set_txn(0, 1'b0, 4'hF, 32'h0000_0008, 32'd0);
        run_round(1'b1, 1'b0, 0, "byte_readback");
        ntot++;
        if (m0_rdata !== 32'h0000_AB00) $display("FAIL byte_write_data: got %h want 0000AB00", m0_rdata);
        else npass++;
    endtask

    task automatic test_reset_mid();
        set_txn(0, 1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_F00D);
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'hF; m0_addr = t_addr[0]; m0_wdata = t_wd[0];
        @(negedge clk);
        ntot++;
        if ({ram_we, busy} !== 2'b11) $display("FAIL reset_mid_pre: got we/busy %b%b want 11", ram_we, busy);
        else npass++;
        res = 1'b0;
        #1;
        ntot++;
        if ({ram_we, busy, m0_ack, m1_ack} !== 4'b0000)
            $display("FAIL reset_mid_abort: got we/busy/ack %b%b%b%b want 0000", ram_we, busy, m0_ack, m1_ack);
        else npass++;
        do_reset();
        @(negedge clk); res = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            ntot++;
            if ({busy, m0_ack, m1_ack} !== 3'b000) $display("FAIL reset_mid_stale: got busy/ack %b%b%b want 000", busy, m0_ack, m1_ack);
            else npass++;
        end
        set_txn(0, 1'b0, 4'hF, 32'h0000_0030, 32'd0);
        set_txn(1, 1'b0, 4'hF, 32'h0000_0014, 32'd0);
        run_round(1'b1, 1'b1, 0, "reset_mid_tie");
    endtask

    task automatic test_hold();
        preload(7, 32'h1234_5678);
        set_txn(1, 1'b0, 4'hF, 32'hF000_001C, 32'd0);
        run_round(1'b0, 1'b1, 0, "hold_m1");
        for (int i = 0; i < 3; i++) begin
            set_txn(0, 1'b0, 4'hF, 32'(i * 4), 32'd0);
            run_round(1'b1, 1'b0, 0, "hold_m0");
        end
        ntot++;
        if (m1_rdata !== 32'h1234_5678) $display("FAIL hold_m1_rdata: got %h want 12345678", m1_rdata);
        else npass++;
    endtask

    task automatic test_req_drop();
        set_txn(1, 1'b0, 4'hF, 32'h0000_001C, 32'd0);
        run_round(1'b0, 1'b1, 1, "req_drop");
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++)
                set_txn(m, 1'($urandom_range(0, 1)), 4'($urandom),
                        ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2), $urandom);
            run_round(r[0], r[1], 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_byte_write();
        test_req_drop();
        test_reset_mid();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous data RAM between two bus masters: m0 (core data port) and m1 (ROM/RAM loader or debug master).
- Sequences each access through grant, wait-state and acknowledge phases, so masters see a simple req/ack handshake.
- Sits between the masters and the RAM array in the top level, and replaces ad-hoc wait-state logic there.

Parameters:
- WAIT_STATES, 1, RAM cycles per access after address phase; legal values 1..15; RAM read data is valid one cycle after address.
- RAM_AW, 10, RAM word-address width; ram_addr = mN_addr[RAM_AW+1:2].

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  asynchronous active-low reset
- m0_req  in  1  m0 access request, level
- m0_we  in  1  m0 write (1) / read (0)
- m0_be  in  4  m0 byte enables
- m0_addr  in  32  m0 byte address
- m0_wdata  in  32  m0 write data
- m0_rdata  out  32  m0 read data, valid while m0_ack=1, held afterwards
- m0_ack  out  1  m0 one-cycle completion pulse
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_rdata, m1_ack: same as m0, for m1
- ram_we  out  1  RAM write strobe
- ram_be  out  4  RAM byte enables
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM registered read data
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (res=0, asynchronous): state=IDLE, owner=0, last=1 (m0 wins the first tie), wcnt=0, all outputs 0, ram_we drops immediately. Reset mid-access aborts the access; no ack is issued.
- IDLE:
  - if any req, select the owner: only one req -> that master; both -> the master != last (round-robin).
  - Latch owner's we/be/addr/wdata into registers, set last=owner, wcnt=0, go to ACCESS.
  - Requests are sampled only in IDLE.
- ACCESS (WAIT_STATES+1 cycles):
  - ram_addr/ram_be/ram_wdata driven from latched registers for the whole state.
  - ram_we=1 only in the first ACCESS cycle and only for writes; single write per transaction.
  - wcnt increments each cycle; at wcnt==WAIT_STATES, capture ram_rdata into owner's rdata register (reads only) and go to ACK.
- ACK (1 cycle): owner's ack=1, other ack=0; next state IDLE.
- Latency: req sampled in IDLE cycle T -> ack in cycle T+WAIT_STATES+2. Back-to-back minimum period is WAIT_STATES+3 cycles.
- Master rules:
  - Hold req and its signals stable until ack.
  - Deassert req the cycle after ack unless issuing a new access.
  - A req still high in the following IDLE is a new transaction.
  - req dropped before ack: the transaction still completes; ack is still pulsed.
- Non-owner's rdata is unchanged by the other master's accesses. Writes leave the owner's rdata unchanged.
- ram_* outputs are 0 in IDLE and ACK.
- busy=1 in ACCESS and ACK.
- wcnt width is 4 bits; no wrap in legal configurations.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN:
- Defined: m0 always wins when both request; `last` is not used for the decision; m1 can starve.
- Undefined: round-robin as described above.

Test Plan:
- Single read, WAIT_STATES=1: preload RAM[5]=32'hDEADBEEF; m0 reads addr 0x14 -> m0_ack at T+3, m0_rdata=DEADBEEF, ram_we never 1.
- Byte write: m1 writes addr 0x8, be=4'b0010, wdata=32'h0000AB00 over RAM[2]=0 -> exactly one ram_we pulse with ram_addr=2; m0 then reads RAM[2]=32'h0000AB00.
- Contention: m0 and m1 both assert req continuously from reset -> grants alternate m0, m1, m0, m1; each ack spaced 4 cycles apart. With MEM_ARB_FIXED_PRIO_EN, only m0 is granted.
- Wait-states: WAIT_STATES=3 -> req-to-ack latency 5 cycles; busy high for exactly 5 cycles per access.
- Reset mid-operation: assert res=0 in the 1st ACCESS cycle of a write -> ram_we, busy, both acks 0 immediately. After release, next tie is granted to m0 and no stale ack appears.
- Hold: after m1 read returns 32'h12345678, m0 performs three reads -> m1_rdata remains 32'h12345678.
